// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD parallel bus engines: FSM encoding, word type and
// default panel timing.
package lcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } lcd_state_e;

  localparam int unsigned LcdDataW     = 16;
  localparam int unsigned LcdSetupCyc  = 1;
  localparam int unsigned LcdWrLowCyc  = 2;
  localparam int unsigned LcdHoldCyc   = 1;

  typedef struct packed {
    logic                rs;
    logic [LcdDataW-1:0] data;
  } lcd_word_t;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_bus_writer_if.sv
// Valid/ready word stream feeding the LCD bus writer.
interface lcd_bus_writer_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              in_rs;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_rs, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_bus_writer_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; push into a full FIFO and pop from an
// empty FIFO are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/lcd_bus_writer.sv
// Buffered 8080-style write engine: queues {rs, data} words and replays them on the panel
// bus with programmable setup / strobe-low / hold timing, sharing one cs window.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned DATA_W     = LcdDataW,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SETUP_CYC  = LcdSetupCyc,
  parameter int unsigned WR_LOW_CYC = LcdWrLowCyc,
  parameter int unsigned HOLD_CYC   = LcdHoldCyc
) (
  input  logic                        clk,
  input  logic                        reset,
  lcd_bus_writer_if.slave             in_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        idle,
  output logic                        lcd_rst,
  output logic                        lcd_cs,
  output logic                        lcd_rs,
  output logic                        lcd_wr,
  output logic                        lcd_rd,
  output logic [DATA_W-1:0]           lcd_data,
  output logic                        lcd_data_oe,
  output logic                        lcd_bl_ctr
);

  localparam int unsigned CntW = $clog2(max3(SETUP_CYC, WR_LOW_CYC, HOLD_CYC) + 1);
  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] WrLowLd = CntW'(WR_LOW_CYC - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);

  lcd_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cs_q, cs_d;
  logic              wr_q, wr_d;
  logic              oe_q, oe_d;
  logic              rs_q, rs_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W:0]   head;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_if.in_valid),
    .wdata_i ({in_if.in_rs, in_if.in_data}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_if.in_ready = reset | ~fifo_full;
  assign idle           = (state_q == StIdle) && fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StSetup;
          cnt_d   = SetupLd;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StStrobe;
          cnt_d   = WrLowLd;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = HoldLd;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          // Chain straight into the next word so cs stays low across the boundary.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StSetup;
            cnt_d   = SetupLd;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin values are derived from the next state so every pin comes straight off a flop.
  always_comb begin
    cs_d   = (state_d == StIdle);
    wr_d   = (state_d != StStrobe);
    oe_d   = (state_d != StIdle);
    rs_d   = pop ? head[DATA_W] : rs_q;
    data_d = pop ? head[DATA_W-1:0] : data_q;
  end

  assign lcd_rst     = ~reset;
  assign lcd_cs      = cs_q;
  assign lcd_wr      = wr_q;
  assign lcd_rs      = rs_q;
  assign lcd_data    = data_q;
  assign lcd_data_oe = oe_q;
  assign lcd_rd      = 1'b1;
  assign lcd_bl_ctr  = 1'b1;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Drives two writers (default timing and 3/1/2 timing) with the same word stream and
// checks every pin each cycle against a word-schedule reference model.
module tb_lcd_bus_writer;

  localparam int DW  = 16;
  localparam int DEP = 8;
  localparam int S0 = 1, W0 = 2, H0 = 1;
  localparam int S1 = 3, W1 = 1, H1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_bus_writer_if #(.DATA_W(DW)) if0 ();
  lcd_bus_writer_if #(.DATA_W(DW)) if1 ();

  logic [3:0]    cnt_w  [2];
  logic [DW-1:0] data_w [2];
  logic [1:0]    idle_w, lrst_w, cs_w, rs_w, wr_w, rd_w, oe_w, bl_w;

  lcd_bus_writer #(
    .DATA_W(DW), .FIFO_DEPTH(DEP), .SETUP_CYC(S0), .WR_LOW_CYC(W0), .HOLD_CYC(H0)
  ) u_dut0 (
    .clk(clk), .reset(rst), .in_if(if0.slave), .fifo_count(cnt_w[0]), .idle(idle_w[0]),
    .lcd_rst(lrst_w[0]), .lcd_cs(cs_w[0]), .lcd_rs(rs_w[0]), .lcd_wr(wr_w[0]),
    .lcd_rd(rd_w[0]), .lcd_data(data_w[0]), .lcd_data_oe(oe_w[0]), .lcd_bl_ctr(bl_w[0])
  );

  lcd_bus_writer #(
    .DATA_W(DW), .FIFO_DEPTH(DEP), .SETUP_CYC(S1), .WR_LOW_CYC(W1), .HOLD_CYC(H1)
  ) u_dut1 (
    .clk(clk), .reset(rst), .in_if(if1.slave), .fifo_count(cnt_w[1]), .idle(idle_w[1]),
    .lcd_rst(lrst_w[1]), .lcd_cs(cs_w[1]), .lcd_rs(rs_w[1]), .lcd_wr(wr_w[1]),
    .lcd_rd(rd_w[1]), .lcd_data(data_w[1]), .lcd_data_oe(oe_w[1]), .lcd_bl_ctr(bl_w[1])
  );

  // Reference model: a queue of pending words plus the word on the bus and its offset
  // within the word period.
  logic [DW:0] mq  [2][DEP];
  int          msz [2];
  int          mhd [2];
  bit          act [2];
  int          off [2];
  logic [DW:0] cur [2];
  bit          vld [2];
  int          idx [2];
  logic [DW:0] wl  [$];
  int          en_pct;
  int          ncmp = 0;
  int          nfail = 0;

  function automatic int sc(input int d);
    return (d == 0) ? S0 : S1;
  endfunction

  function automatic int wc(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic int per(input int d);
    return (d == 0) ? (S0 + W0 + H0) : (S1 + W1 + H1);
  endfunction

  task automatic chk(input int d, input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL d%0d %s: observed %0h expected %0h", d, tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      logic [DW:0] w;
      w = (idx[d] < wl.size()) ? wl[idx[d]] : '0;
      vld[d] = (idx[d] < wl.size()) && ($urandom_range(99) < en_pct);
      if (d == 0) begin
        if0.in_valid = vld[d]; if0.in_rs = w[DW]; if0.in_data = w[DW-1:0];
      end else begin
        if1.in_valid = vld[d]; if1.in_rs = w[DW]; if1.in_data = w[DW-1:0];
      end
    end
  endtask

  task automatic model_edge(input int d);
    bit acc, pop;
    if (rst) begin
      msz[d] = 0; mhd[d] = 0; act[d] = 0; off[d] = 0; cur[d] = '0;
    end else begin
      acc = vld[d] && (msz[d] < DEP);
      pop = 0;
      if (act[d]) begin
        off[d]++;
        if (off[d] == per(d)) begin
          if (msz[d] > 0) pop = 1;
          else act[d] = 0;
        end
      end else if (msz[d] > 0) begin
        pop = 1;
      end
      if (pop) begin
        cur[d] = mq[d][mhd[d]];
        mhd[d] = (mhd[d] + 1) % DEP;
        msz[d]--;
        act[d] = 1;
        off[d] = 0;
      end
      if (acc) begin
        mq[d][(mhd[d] + msz[d]) % DEP] = wl[idx[d]];
        msz[d]++;
        idx[d]++;
      end
    end
  endtask

  task automatic check(input int d);
    bit strobe;
    logic rdy;
    strobe = act[d] && (off[d] >= sc(d)) && (off[d] < sc(d) + wc(d));
    rdy = (d == 0) ? if0.in_ready : if1.in_ready;
    chk(d, "lcd_cs", 32'(cs_w[d]), 32'(!act[d]));
    chk(d, "lcd_wr", 32'(wr_w[d]), 32'(!strobe));
    chk(d, "lcd_data_oe", 32'(oe_w[d]), 32'(act[d]));
    chk(d, "lcd_rs", 32'(rs_w[d]), 32'(cur[d][DW]));
    chk(d, "lcd_data", 32'(data_w[d]), 32'(cur[d][DW-1:0]));
    chk(d, "fifo_count", 32'(cnt_w[d]), 32'(msz[d]));
    chk(d, "idle", 32'(idle_w[d]), 32'(!act[d] && msz[d] == 0));
    chk(d, "in_ready", 32'(rdy), 32'(rst ? 1'b1 : (msz[d] < DEP)));
    chk(d, "lcd_rst", 32'(lrst_w[d]), 32'(!rst));
    chk(d, "lcd_rd_bl", 32'({rd_w[d], bl_w[d]}), 32'h3);
  endtask

  task automatic cycle();
    drive();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check(0);
    check(1);
  endtask

  task automatic run_words(input int max_cyc);
    idx[0] = 0;
    idx[1] = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (idx[0] >= wl.size() && idx[1] >= wl.size() && !act[0] && !act[1] &&
          msz[0] == 0 && msz[1] == 0) break;
      cycle();
    end
    chk(0, "drain_idle", 32'(idle_w[0]), 32'h1);
    chk(1, "drain_idle", 32'(idle_w[1]), 32'h1);
  endtask

  initial begin
    bit found;
    for (int d = 0; d < 2; d++) begin
      msz[d] = 0; mhd[d] = 0; act[d] = 0; off[d] = 0; cur[d] = '0; vld[d] = 0; idx[d] = 0;
    end
    en_pct = 100;
    wl = {};
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;

    // Single command word on an idle block.
    wl = {17'h0002C};
    run_words(40);

    // Twelve back-to-back data words, valid held high; overflows the queue.
    wl = {};
    for (int i = 1; i <= 12; i++) wl.push_back({1'b1, 16'(i)});
    run_words(200);

    // Reset during a strobe with at least five words queued.
    wl = {};
    for (int i = 0; i < 10; i++) wl.push_back(17'($urandom));
    idx[0] = 0;
    idx[1] = 0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      cycle();
      found = act[0] && off[0] >= S0 && off[0] < S0 + W0 && msz[0] >= 5;
    end
    chk(0, "reached_strobe", 32'(wr_w[0]), 32'h0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wl = {17'h1A5A5};
    run_words(60);

    // rs alternating across three words.
    wl = {17'h01111, 17'h12222, 17'h03333};
    run_words(80);

    // Random words with varying producer duty cycle.
    for (int r = 0; r < 3; r++) begin
      en_pct = (r == 0) ? 30 : (r == 1) ? 70 : 100;
      wl = {};
      for (int i = 0; i < 40; i++) wl.push_back(17'($urandom));
      run_words(800);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_writer.md
Name: lcd_bus_writer

Overview:
- Parametrised successor to the single-word LCD poster: a buffered 8080-style parallel write engine for the board's TFT panel.
- Accepts {rs, data} words on a valid/ready stream, queues them in an internal FIFO and replays them with programmable setup, strobe-low and hold timing.
- Back-to-back words share one chip-select window.
- Sits between the CPU-side LCD MMIO register and the panel pins; replaces toggle-flag posting with true flow control.

Parameters:
DATA_W, 16, panel data bus width
FIFO_DEPTH, 8, queue entries; power of two, >= 2
SETUP_CYC, 1, cycles data/rs/cs are stable before lcd_wr falls; >= 1
WR_LOW_CYC, 2, cycles lcd_wr is held low; >= 1
HOLD_CYC, 1, cycles lcd_wr is high with data held after the rising edge; >= 1

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  producer has a word
in_ready  out  1  FIFO can accept; combinational, equals !full
in_rs  in  1  0 = command, 1 = data
in_data  in  DATA_W  word to post
fifo_count  out  log2(FIFO_DEPTH)+1  entries queued, excluding the word on the bus
idle  out  1  FIFO empty and FSM in IDLE
lcd_rst  out  1  panel reset, active low; equals ~reset
lcd_cs  out  1  chip select, active low
lcd_rs  out  1  registered rs of the current word
lcd_wr  out  1  write strobe, active low
lcd_rd  out  1  tied 1
lcd_data  out  DATA_W  registered data of the current word
lcd_data_oe  out  1  1 while cs is low; drives the top-level tristate
lcd_bl_ctr  out  1  tied 1 (backlight on)

Behaviour:
- Reset (any cycle, including mid-transfer): on the next edge state=IDLE, FIFO emptied, counters 0, lcd_cs=1, lcd_wr=1, lcd_rs=0, lcd_data=0, lcd_data_oe=0, fifo_count=0, idle=1. Queued and in-flight words are dropped; no partial strobe completes. While reset is high, pushes are ignored and in_ready reads 1.
- Push: in_valid && in_ready at an edge writes the word and increments count. in_ready depends only on the registered count. A pop in the same cycle does not enable a push into a full FIFO.
- Simultaneous push and pop: count unchanged; order is preserved.
- FSM states: IDLE, SETUP, STROBE, HOLD. One down-counter is loaded on each state entry.
- IDLE: if count != 0, pop the head at the edge, load lcd_rs/lcd_data, set cs=0 and oe=1, go to SETUP. Otherwise cs=1 and oe=0.
- SETUP: lcd_wr=1 for SETUP_CYC cycles, then go to STROBE.
- STROBE: lcd_wr=0 for WR_LOW_CYC cycles, then go to HOLD.
- HOLD: lcd_wr=1 for HOLD_CYC cycles, data unchanged. At the final edge:
  - if count != 0: pop the next word, load the registers, go to SETUP; cs stays 0 with no glitch.
  - else: go to IDLE with cs=1 and oe=0.
- Latency: a word accepted at edge k into an empty, idle block drives cs low from edge k+1. lcd_wr is low from edge k+1+SETUP_CYC for WR_LOW_CYC cycles. The word period is SETUP_CYC+WR_LOW_CYC+HOLD_CYC cycles.
- lcd_wr, lcd_cs and lcd_data are all registered outputs (no combinational paths to pins).
- Count width holds 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- idle = (state==IDLE) && (count==0). It is 0 in the cycle a push lands.

Decomposition:
- Shared package (lcd_pkg): FSM state encoding (IDLE/SETUP/STROBE/HOLD) and an lcd word type {rs, data[DATA_W-1:0]}. Default timing constants live there for reuse by a future read engine.
- One natural sub-module: sync_fifo (parametrised width/depth, registered count, full/empty flags). Instantiated with width DATA_W+1.

Test Plan:
- Defaults; push {rs=0, 0x002C} once on an empty block → cs low for exactly 4 cycles starting 1 cycle after accept; wr low in cycles 2-3 of that window; lcd_data=0x002C, rs=0 throughout; idle returns to 1.
- Hold in_valid high for 12 consecutive words 0x0001..0x000C (rs=1) → in_ready drops when count=8; all 12 emerge in order; exactly 12 wr-low pulses; cs low continuously for 48 cycles; fifo_count never exceeds 8.
- Fill to 8 while the engine is stalled mid-word; keep in_valid high → no push is accepted while in_ready=0; the first push after the pop lands next cycle; no word is lost or duplicated.
- Assert reset for 1 cycle during STROBE with 5 queued → next cycle wr=1, cs=1, oe=0, fifo_count=0, idle=1; a subsequent single push is posted normally.
- SETUP_CYC=3, WR_LOW_CYC=1, HOLD_CYC=2; push two words → per word: wr low exactly 1 cycle, 3 cycles after data change; 6-cycle period; cs low for 12 contiguous cycles.
- Alternate rs 0/1/0 across 3 words → lcd_rs changes only at word boundaries (SETUP entry), never while wr is low.
